// File: rtl/mem_write_checker.sv
// In-order checker for data-memory writes against a loaded (addr,data) table.
// Define WCHK_STRICT_EN to end the run with FAIL on the first mismatching write.
module mem_write_checker #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TIMEOUT_W = 16,
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemWrite,
  input  logic [ADDR_W-1:0]    DataAdr,
  input  logic [DATA_W-1:0]    WriteData,
  input  logic                 exp_we,
  input  logic [IdxW-1:0]      exp_idx,
  input  logic [ADDR_W-1:0]    exp_addr,
  input  logic [DATA_W-1:0]    exp_data,
  input  logic [CntW-1:0]      exp_count,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic                 start,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 tmo,
  output logic [CntW-1:0]      match_cnt,
  output logic [15:0]          wr_cnt,
  output logic [ADDR_W-1:0]    err_addr,
  output logic [DATA_W-1:0]    err_data
);

  localparam int unsigned WordW = ADDR_W + DATA_W;

  typedef enum logic [2:0] {StIdle, StRun, StPass, StFail, StTmo} state_e;

  state_e                 state_q, state_d;
  logic [WordW-1:0]       tbl_q [DEPTH];
  logic [CntW-1:0]        ptr_q, ptr_d;
  logic [CntW-1:0]        lim_q, lim_d;
  logic [TIMEOUT_W-1:0]   tlim_q, tlim_d;
  logic [TIMEOUT_W-1:0]   cyc_q, cyc_d;
  logic [15:0]            wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]      err_addr_q, err_addr_d;
  logic [DATA_W-1:0]      err_data_q, err_data_d;
  logic                   err_vld_q, err_vld_d;
  logic                   hit, miss;
  logic [WordW-1:0]       wr_word;

  assign wr_word = {DataAdr, WriteData};

  // Table is not reset so it survives a reset and can be rerun unchanged.
  always_ff @(posedge clk) begin
    if (state_q == StIdle && exp_we) begin
      tbl_q[exp_idx] <= {exp_addr, exp_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      lim_q      <= '0;
      tlim_q     <= '0;
      cyc_q      <= '0;
      wr_cnt_q   <= '0;
      err_addr_q <= '0;
      err_data_q <= '0;
      err_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lim_q      <= lim_d;
      tlim_q     <= tlim_d;
      cyc_q      <= cyc_d;
      wr_cnt_q   <= wr_cnt_d;
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
      err_vld_q  <= err_vld_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lim_d      = lim_q;
    tlim_d     = tlim_q;
    cyc_d      = cyc_q;
    wr_cnt_d   = wr_cnt_q;
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    err_vld_d  = err_vld_q;
    hit        = 1'b0;
    miss       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          lim_d      = (exp_count > CntW'(DEPTH)) ? CntW'(DEPTH) : exp_count;
          tlim_d     = timeout;
          cyc_d      = '0;
          ptr_d      = '0;
          wr_cnt_d   = '0;
          err_addr_d = '0;
          err_data_d = '0;
          err_vld_d  = 1'b0;
          state_d    = (exp_count == '0) ? StPass : StRun;
        end
      end
      StRun: begin
        cyc_d = cyc_q + TIMEOUT_W'(1);
        if (MemWrite && wr_cnt_q != 16'hFFFF) begin
          wr_cnt_d = wr_cnt_q + 16'd1;
        end
        // Case equality: any X/Z on the bus counts as a mismatch.
        hit  = MemWrite && (wr_word === tbl_q[ptr_q[IdxW-1:0]]);
        miss = MemWrite && !hit;
        if (miss && !err_vld_q) begin
          err_addr_d = DataAdr;
          err_data_d = WriteData;
          err_vld_d  = 1'b1;
        end
        if (hit) begin
          ptr_d = ptr_q + CntW'(1);
        end
        if (hit && ptr_d == lim_q) begin
          state_d = StPass;
`ifdef WCHK_STRICT_EN
        end else if (miss) begin
          state_d = StFail;
`endif
        end else if (tlim_q != '0 && cyc_d == tlim_q) begin
          state_d = StTmo;
        end
      end
      default: ;
    endcase
  end

  assign pass      = (state_q == StPass);
`ifdef WCHK_STRICT_EN
  assign fail      = (state_q == StFail);
`else
  assign fail      = 1'b0;
`endif
  assign tmo       = (state_q == StTmo);
  assign done      = pass | fail | tmo;
  assign match_cnt = ptr_q;
  assign wr_cnt    = wr_cnt_q;
  assign err_addr  = err_addr_q;
  assign err_data  = err_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed self-checking bench for mem_write_checker (default DEPTH=8 build).
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        exp_we;
  logic [2:0]  exp_idx;
  logic [31:0] exp_addr;
  logic [31:0] exp_data;
  logic [3:0]  exp_count;
  logic [15:0] timeout;
  logic        start;
  logic        done, pass, fail, tmo;
  logic [3:0]  match_cnt;
  logic [15:0] wr_cnt;
  logic [31:0] err_addr, err_data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_write_checker dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .exp_we    (exp_we),
    .exp_idx   (exp_idx),
    .exp_addr  (exp_addr),
    .exp_data  (exp_data),
    .exp_count (exp_count),
    .timeout   (timeout),
    .start     (start),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .tmo       (tmo),
    .match_cnt (match_cnt),
    .wr_cnt    (wr_cnt),
    .err_addr  (err_addr),
    .err_data  (err_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at negedge; outputs are sampled at the following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [2:0] i, input logic [31:0] a, input logic [31:0] d);
    exp_we = 1'b1; exp_idx = i; exp_addr = a; exp_data = d;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic run(input logic [3:0] cnt, input logic [15:0] to);
    exp_count = cnt; timeout = to; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_flags"}, {60'd0, done, pass, fail, tmo}, 64'd0);
    check_eq({tag, "_cnts"}, {44'd0, match_cnt, wr_cnt}, 64'd0);
    check_eq({tag, "_err"}, {err_addr, err_data}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    exp_we = 1'b0; exp_idx = '0; exp_addr = '0; exp_data = '0;
    exp_count = '0; timeout = '0; start = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset();
    check_zero("rst");

    // Single-entry pass, with an X write rejected first
    load(3'd0, 32'd252, 32'd22);
    run(4'd1, 16'd0);
    check_eq("t1_run_pass", {63'd0, pass}, 64'd0);
    wr(32'hxxxx_xxxx, 32'd22);
    check_eq("t1_x_match", {60'd0, match_cnt}, 64'd0);
    check_eq("t1_x_errdata", {32'd0, err_data}, 64'd22);
    wr(32'd252, 32'd22);
    check_eq("t1_flags", {60'd0, done, pass, fail, tmo}, 64'b1100);
    check_eq("t1_match", {60'd0, match_cnt}, 64'd1);
    check_eq("t1_wrcnt", {48'd0, wr_cnt}, 64'd2);
    // start in PASS is ignored
    run(4'd0, 16'd0);
    check_eq("t1_hold", {59'd0, pass, match_cnt}, {59'd0, 1'b1, 4'd1});

    // Two entries with a mismatch in between
    do_reset();
    load(3'd0, 32'd96, 32'd7);
    load(3'd1, 32'd252, 32'd22);
    run(4'd2, 16'd0);
    wr(32'd96, 32'd7);
    check_eq("t2_match1", {60'd0, match_cnt}, 64'd1);
    wr(32'd100, 32'd5);
    check_eq("t2_err", {err_addr, err_data}, {32'd100, 32'd5});
    check_eq("t2_match2", {60'd0, match_cnt}, 64'd1);
`ifdef WCHK_STRICT_EN
    check_eq("t2_fail", {60'd0, done, pass, fail, tmo}, 64'b1010);
`else
    check_eq("t3_nofail", {60'd0, done, pass, fail, tmo}, 64'b0000);
    wr(32'd44, 32'd9);
    check_eq("t3_errhold", {err_addr, err_data}, {32'd100, 32'd5});
    wr(32'd252, 32'd22);
    check_eq("t3_pass", {60'd0, done, pass, fail, tmo}, 64'b1100);
    check_eq("t3_wrcnt", {48'd0, wr_cnt}, 64'd4);
    check_eq("t3_match", {60'd0, match_cnt}, 64'd2);
`endif

    // Timeout exactly 20 cycles after start
    do_reset();
    load(3'd0, 32'd252, 32'd22);
    run(4'd1, 16'd20);
    for (int i = 0; i < 19; i++) tick();
    check_eq("t4_pre", {60'd0, done, pass, fail, tmo}, 64'b0000);
    tick();
    check_eq("t4_tmo", {60'd0, done, pass, fail, tmo}, 64'b1001);

    // Final match on the timeout edge: PASS wins
    do_reset();
    load(3'd0, 32'd252, 32'd22);
    run(4'd1, 16'd3);
    tick();
    tick();
    wr(32'd252, 32'd22);
    check_eq("t5_pass_wins", {60'd0, done, pass, fail, tmo}, 64'b1100);

    // exp_count = 0 passes on the start edge
    do_reset();
    run(4'd0, 16'd0);
    check_eq("t5_zero", {60'd0, done, pass, fail, tmo}, 64'b1100);
    check_eq("t5_zero_match", {60'd0, match_cnt}, 64'd0);

    // exp_count above DEPTH clamps to 8
    do_reset();
    for (int i = 0; i < 8; i++) load(3'(i), 32'(16 + i), 32'(i * 3));
    run(4'd15, 16'd0);
    for (int i = 0; i < 7; i++) wr(32'(16 + i), 32'(i * 3));
    check_eq("clamp_pre", {59'd0, pass, match_cnt}, {59'd0, 1'b0, 4'd7});
    wr(32'd23, 32'd21);
    check_eq("clamp_pass", {59'd0, pass, match_cnt}, {59'd0, 1'b1, 4'd8});

    // Reset mid-run, then rerun with the retained table
    do_reset();
    load(3'd0, 32'd96, 32'd7);
    load(3'd1, 32'd252, 32'd22);
    run(4'd2, 16'd0);
    wr(32'd96, 32'd7);
    check_eq("t6_match1", {60'd0, match_cnt}, 64'd1);
    reset = 1'b1;
    tick();
    check_zero("t6_rst");
    reset = 1'b0;
    run(4'd2, 16'd0);
    load(3'd0, 32'd1, 32'd1);
    wr(32'd96, 32'd7);
    check_eq("t6_restart", {60'd0, match_cnt}, 64'd1);
    wr(32'd252, 32'd22);
    check_eq("t6_pass", {60'd0, done, pass, fail, tmo}, 64'b1100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
